inst_queue: RTL and testbench

Instruction queue between the icache read port and ID. It captures 1–4 sequential instructions per cycle from the fetch path and buffers them in a circular queue. It presents up to two instructions per cycle in program order to decode, and is emptied on a branch-mispredict or exception flush. Backpressure to IF/icache is asserted through `iq_allin`.

---
 rtl/inst_queue_pkg.sv | 27 ++
 rtl/inst_queue_regfile.sv | 52 +++++
 rtl/inst_queue.sv | 136 +++++++++++++
 tb/tb_inst_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
// Shared definitions for the instruction queue: default depth, pointer width,
// the layout of one queue entry {pc, insn, delot}, and a packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_queue_pkg;

   localparam int IQ_DEPTH     = 16;
   localparam int IQ_PTR_W     = $clog2(IQ_DEPTH);
   localparam int IQ_ENTRY_W   = 65;
   localparam int IQ_GROUP_MAX = 4;

   // Entry field positions: {pc[31:0], insn[31:0], delot}
   localparam int IQ_DELOT_BIT = 0;
   localparam int IQ_INSN_LSB  = 1;
   localparam int IQ_INSN_MSB  = 32;
   localparam int IQ_PC_LSB    = 33;
   localparam int IQ_PC_MSB    = 64;

   function automatic logic [IQ_ENTRY_W-1:0] iq_pack(input logic [31:0] pc,
                                                     input logic [31:0] insn,
                                                     input logic        delot);
      return {pc, insn, delot};
   endfunction

endpackage

// File: rtl/inst_queue_regfile.sv
// -----------------------------------------------------------------------------
// iq_regfile
// DEPTH x IQ_ENTRY_W storage for the instruction queue. Four write ports share
// one base address; port i writes entry (wr_base + i) mod DEPTH when wr_en[i].
// Two asynchronous read ports.
//   clk       in   clock
//   wr_en     in   per-slot write enable
//   wr_base   in   address of slot 0
//   wr_data   in   slot i entry at [IQ_ENTRY_W*i +: IQ_ENTRY_W]
//   rd_addr0/1 in  read addresses
//   rd_data0/1 out read data (combinational)
// -----------------------------------------------------------------------------
module iq_regfile
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                               clk,
   input  logic [IQ_GROUP_MAX-1:0]            wr_en,
   input  logic [PTR_W-1:0]                   wr_base,
   input  logic [IQ_GROUP_MAX*IQ_ENTRY_W-1:0] wr_data,
   input  logic [PTR_W-1:0]                   rd_addr0,
   input  logic [PTR_W-1:0]                   rd_addr1,
   output logic [IQ_ENTRY_W-1:0]              rd_data0,
   output logic [IQ_ENTRY_W-1:0]              rd_data1
);

   logic [IQ_ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_addr [IQ_GROUP_MAX];

   // Pointer arithmetic is PTR_W wide, so a group straddling DEPTH-1 wraps to 0.
   always_comb begin
      for (int i = 0; i < IQ_GROUP_MAX; i++) begin
         wr_addr[i] = wr_base + PTR_W'(i);
      end
   end

   // NOTE: storage has no reset; validity is tracked by the pointers and count,
   // so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IQ_GROUP_MAX; i++) begin
         if (wr_en[i]) begin
            mem[wr_addr[i]] <= wr_data[i*IQ_ENTRY_W +: IQ_ENTRY_W];
         end
      end
   end

   assign rd_data0 = mem[rd_addr0];
   assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Circular instruction queue between the icache read port and ID. Accepts a
// group of 1-4 sequential instructions per cycle, presents up to two in
// program order, and empties on a mispredict or exception flush.
//   clk, rst_                 clock, synchronous active-low reset
//   icache_iq_valid/pc/cnt/insn/delot_en   fetch group in
//   iq_allin                  queue can take a full 4-instruction group
//   iq_id_valid               00 empty, 01 one entry, 11 two or more
//   iq_id_pc0/1, insn0/1, delot0/1         head and head+1 entries
//   id_iq_take                instructions consumed by ID this cycle
//   ex_bp_error, exc_flush_all            flush requests
// -----------------------------------------------------------------------------
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH   = IQ_DEPTH,
   parameter int ISSUE_W = 2
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         icache_iq_valid,
   input  logic [31:0]  icache_iq_pc,
   input  logic [2:0]   icache_iq_cnt,
   input  logic [127:0] icache_iq_insn,
   input  logic         icache_iq_delot_en,
   output logic         iq_allin,
   output logic [1:0]   iq_id_valid,
   output logic [31:0]  iq_id_pc0,
   output logic [31:0]  iq_id_pc1,
   output logic [31:0]  iq_id_insn0,
   output logic [31:0]  iq_id_insn1,
   output logic         iq_id_delot0,
   output logic         iq_id_delot1,
   input  logic [1:0]   id_iq_take,
   input  logic         ex_bp_error,
   input  logic         exc_flush_all
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                               flush;
   logic                               grp_ok;
   logic                               wr;
   logic [CNT_W-1:0]                   wr_cnt;
   logic [CNT_W-1:0]                   take;
   logic [CNT_W-1:0]                   rd;
   logic [IQ_GROUP_MAX-1:0]            wr_en;
   logic [IQ_GROUP_MAX*IQ_ENTRY_W-1:0] wr_data;
   logic [PTR_W-1:0]                   rd_addr1;
   logic [IQ_ENTRY_W-1:0]              rd_data0, rd_data1;

   // NOTE: every combinational output gets a value before any branch, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      flush    = ex_bp_error | exc_flush_all;
      // Decided from registered count only; a drain this cycle does not help.
      iq_allin = (count_q <= CNT_W'(DEPTH - IQ_GROUP_MAX));
      // cnt = 0 means nothing to write; cnt > 4 is illegal and also dropped.
      grp_ok   = (icache_iq_cnt != 3'd0) && (icache_iq_cnt <= 3'(IQ_GROUP_MAX));
      wr       = icache_iq_valid && iq_allin && !flush && grp_ok;
      wr_cnt   = wr ? CNT_W'(icache_iq_cnt) : '0;

      // Clamp the take to the issue width and then to what is actually held.
      take = CNT_W'(id_iq_take);
      if (take > CNT_W'(ISSUE_W)) take = CNT_W'(ISSUE_W);
      rd   = (take > count_q) ? count_q : take;

      wptr_d  = wptr_q + PTR_W'(wr_cnt);
      rptr_d  = rptr_q + PTR_W'(rd);
      count_d = count_q + wr_cnt - rd;

      // Flush wins over both the write and the take.
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end

      for (int i = 0; i < IQ_GROUP_MAX; i++) begin
         wr_en[i] = wr && (icache_iq_cnt > 3'(i));
         wr_data[i*IQ_ENTRY_W +: IQ_ENTRY_W] =
            iq_pack(icache_iq_pc + 32'(4 * i),
                    icache_iq_insn[32*i +: 32],
                    (i == 0) ? icache_iq_delot_en : 1'b0);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign rd_addr1 = rptr_q + PTR_W'(1);

   iq_regfile #(.DEPTH(DEPTH)) u_rf (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_base  (wptr_q),
      .wr_data  (wr_data),
      .rd_addr0 (rptr_q),
      .rd_addr1 (rd_addr1),
      .rd_data0 (rd_data0),
      .rd_data1 (rd_data1)
   );

   always_comb begin
      if (count_q == '0)                iq_id_valid = 2'b00;
      else if (count_q == CNT_W'(1))    iq_id_valid = 2'b01;
      else                              iq_id_valid = 2'b11;
      iq_id_pc0    = rd_data0[IQ_PC_MSB:IQ_PC_LSB];
      iq_id_insn0  = rd_data0[IQ_INSN_MSB:IQ_INSN_LSB];
      iq_id_delot0 = rd_data0[IQ_DELOT_BIT];
      iq_id_pc1    = rd_data1[IQ_PC_MSB:IQ_PC_LSB];
      iq_id_insn1  = rd_data1[IQ_INSN_MSB:IQ_INSN_LSB];
      iq_id_delot1 = rd_data1[IQ_DELOT_BIT];
   end

   cnt_legal_a: assert property (@(posedge clk) disable iff (!rst_)
      icache_iq_valid |-> (icache_iq_cnt <= 3'(IQ_GROUP_MAX)));

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
// Directed stimulus for inst_queue. Accepted groups are pushed into a
// scoreboard queue; a negedge monitor compares the presented slots, valid and
// allin against the scoreboard and pops whatever ID takes.
// -----------------------------------------------------------------------------
module tb_inst_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        delot;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst_;
   logic         icache_iq_valid;
   logic [31:0]  icache_iq_pc;
   logic [2:0]   icache_iq_cnt;
   logic [127:0] icache_iq_insn;
   logic         icache_iq_delot_en;
   logic         iq_allin;
   logic [1:0]   iq_id_valid;
   logic [31:0]  iq_id_pc0, iq_id_pc1, iq_id_insn0, iq_id_insn1;
   logic         iq_id_delot0, iq_id_delot1;
   logic [1:0]   id_iq_take;
   logic         ex_bp_error;
   logic         exc_flush_all;

   int   checks   = 0;
   int   failures = 0;
   ent_t sb[$];

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(16), .ISSUE_W(2)) dut (
      .clk                (clk),
      .rst_               (rst_),
      .icache_iq_valid    (icache_iq_valid),
      .icache_iq_pc       (icache_iq_pc),
      .icache_iq_cnt      (icache_iq_cnt),
      .icache_iq_insn     (icache_iq_insn),
      .icache_iq_delot_en (icache_iq_delot_en),
      .iq_allin           (iq_allin),
      .iq_id_valid        (iq_id_valid),
      .iq_id_pc0          (iq_id_pc0),
      .iq_id_pc1          (iq_id_pc1),
      .iq_id_insn0        (iq_id_insn0),
      .iq_id_insn1        (iq_id_insn1),
      .iq_id_delot0       (iq_id_delot0),
      .iq_id_delot1       (iq_id_delot1),
      .id_iq_take         (id_iq_take),
      .ex_bp_error        (ex_bp_error),
      .exc_flush_all      (exc_flush_all)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: outputs are stable at negedge; inputs change only after posedge.
   always @(negedge clk) begin
      int n;
      if (rst_) begin
         check("mon_valid", iq_id_valid,
               (sb.size() == 0) ? 2'b00 : (sb.size() == 1) ? 2'b01 : 2'b11);
         check("mon_allin", iq_allin, sb.size() <= 12);
         if (sb.size() >= 1) begin
            check("mon_pc0",    iq_id_pc0,    sb[0].pc);
            check("mon_insn0",  iq_id_insn0,  sb[0].insn);
            check("mon_delot0", iq_id_delot0, sb[0].delot);
         end
         if (sb.size() >= 2) begin
            check("mon_pc1",    iq_id_pc1,    sb[1].pc);
            check("mon_insn1",  iq_id_insn1,  sb[1].insn);
            check("mon_delot1", iq_id_delot1, sb[1].delot);
         end
         if (!(ex_bp_error || exc_flush_all)) begin
            n = int'(id_iq_take);
            if (n > sb.size()) n = sb.size();
            for (int k = 0; k < n; k++) void'(sb.pop_front());
         end
      end
   end

   // One cycle of stimulus. acc is the hand-derived expectation of whether
   // the group is accepted; accepted slots go into the scoreboard.
   task automatic cyc(input logic v, input logic [31:0] pc, input logic [2:0] cnt,
                      input logic dl, input logic [1:0] take, input logic acc,
                      input logic bp = 1'b0, input logic exc = 1'b0);
      ent_t e;
      icache_iq_valid    = v;
      icache_iq_pc       = pc;
      icache_iq_cnt      = cnt;
      icache_iq_delot_en = dl;
      for (int i = 0; i < 4; i++) icache_iq_insn[32*i +: 32] = ~(pc + 32'(4 * i));
      id_iq_take         = take;
      ex_bp_error        = bp;
      exc_flush_all      = exc;
      @(posedge clk);
      #1;
      if (bp || exc) begin
         sb.delete();
      end else if (acc) begin
         for (int i = 0; i < int'(cnt); i++) begin
            e.pc    = pc + 32'(4 * i);
            e.insn  = ~(pc + 32'(4 * i));
            e.delot = (i == 0) ? dl : 1'b0;
            sb.push_back(e);
         end
      end
      icache_iq_valid = 1'b0;
      id_iq_take      = 2'd0;
      ex_bp_error     = 1'b0;
      exc_flush_all   = 1'b0;
   endtask

   task automatic chk_state(input string name, input int cnt, input logic [1:0] vld,
                            input logic allin);
      check({name, "_count"}, 64'(dut.count_q), 64'(cnt));
      check({name, "_valid"}, iq_id_valid, vld);
      check({name, "_allin"}, iq_allin, allin);
   endtask

   initial begin
      rst_ = 1'b0;
      icache_iq_valid = 1'b0; icache_iq_pc = '0; icache_iq_cnt = '0;
      icache_iq_insn = '0; icache_iq_delot_en = 1'b0; id_iq_take = '0;
      ex_bp_error = 1'b0; exc_flush_all = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_ = 1'b1;
      chk_state("reset", 0, 2'b00, 1'b1);

      // First group: visible one cycle after the write edge.
      cyc(1'b1, 32'hBFC0_0000, 3'd4, 1'b0, 2'd0, 1'b1);
      chk_state("first", 4, 2'b11, 1'b1);
      check("first_pc0", iq_id_pc0, 32'hBFC0_0000);
      check("first_pc1", iq_id_pc1, 32'hBFC0_0004);

      // Fill to the full boundary.
      cyc(1'b1, 32'h0000_1000, 3'd4, 1'b0, 2'd0, 1'b1);
      cyc(1'b1, 32'h0000_2000, 3'd4, 1'b0, 2'd0, 1'b1);
      chk_state("fill12", 12, 2'b11, 1'b1);
      cyc(1'b1, 32'h0000_3000, 3'd1, 1'b0, 2'd0, 1'b1);
      chk_state("fill13", 13, 2'b11, 1'b0);
      cyc(1'b1, 32'h0000_4000, 3'd4, 1'b0, 2'd0, 1'b0);
      chk_state("blocked", 13, 2'b11, 1'b0);
      // Push with a take while allin=0: take happens, push is still dropped.
      cyc(1'b1, 32'h0000_5000, 3'd1, 1'b0, 2'd2, 1'b0);
      chk_state("drain11", 11, 2'b11, 1'b1);

      // Drain to one entry, then clamp a take of 2 against count 1.
      repeat (5) cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 1'b0);
      chk_state("drain1", 1, 2'b01, 1'b1);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 1'b0);
      chk_state("clamp", 0, 2'b00, 1'b1);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 1'b0);
      chk_state("empty_take", 0, 2'b00, 1'b1);

      // Pointers are at 13; move both to 14, then write across the wrap.
      cyc(1'b1, 32'h0000_0050, 3'd1, 1'b0, 2'd0, 1'b1);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 1'b0);
      cyc(1'b1, 32'h0000_0100, 3'd4, 1'b0, 2'd0, 1'b1);
      check("wrap_wptr", 64'(dut.wptr_q), 64'd2);
      check("wrap_pc0", iq_id_pc0, 32'h0000_0100);
      check("wrap_pc1", iq_id_pc1, 32'h0000_0104);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 1'b0);
      check("wrap_s1_pc0", iq_id_pc0, 32'h0000_0104);
      check("wrap_s1_pc1", iq_id_pc1, 32'h0000_0108);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 1'b0);
      chk_state("wrap_tail", 1, 2'b01, 1'b1);
      check("wrap_tail_pc0", iq_id_pc0, 32'h0000_010C);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 1'b0);

      // Simultaneous write and take.
      cyc(1'b1, 32'h0000_0200, 3'd3, 1'b0, 2'd0, 1'b1);
      cyc(1'b1, 32'h0000_0300, 3'd3, 1'b0, 2'd2, 1'b1);
      chk_state("simul", 4, 2'b11, 1'b1);
      check("simul_pc0", iq_id_pc0, 32'h0000_0208);
      check("simul_pc1", iq_id_pc1, 32'h0000_0300);

      // Mispredict flush with a write and take in the same cycle.
      cyc(1'b1, 32'h0000_0400, 3'd3, 1'b0, 2'd0, 1'b1);
      chk_state("pre_bp", 7, 2'b11, 1'b1);
      cyc(1'b1, 32'h0000_0500, 3'd4, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
      chk_state("bp_flush", 0, 2'b00, 1'b1);

      // Exception flush.
      cyc(1'b1, 32'h0000_0700, 3'd4, 1'b0, 2'd0, 1'b1);
      cyc(1'b1, 32'h0000_0710, 3'd3, 1'b0, 2'd0, 1'b1);
      chk_state("pre_exc", 7, 2'b11, 1'b1);
      cyc(1'b1, 32'h0000_0720, 3'd4, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
      chk_state("exc_flush", 0, 2'b00, 1'b1);

      // Delay-slot group after the flush.
      cyc(1'b1, 32'h0000_0800, 3'd2, 1'b1, 2'd0, 1'b1);
      check("dslot_pc0", iq_id_pc0, 32'h0000_0800);
      check("dslot_delot0", iq_id_delot0, 1'b1);
      check("dslot_delot1", iq_id_delot1, 1'b0);

      // Reset mid-operation discards the contents.
      rst_ = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      rst_ = 1'b1;
      chk_state("mid_reset", 0, 2'b00, 1'b1);

      cyc(1'b1, 32'h0000_0900, 3'd2, 1'b0, 2'd0, 1'b1);
      chk_state("post_reset", 2, 2'b11, 1'b1);
      cyc(1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 1'b0);
      chk_state("final", 0, 2'b00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
